data_mem_responder: RTL and testbench



---
 rtl/riscv_mem_pkg.sv | 31 +++
 rtl/mem_lane_align.sv | 80 ++++++++
 rtl/data_mem_responder.sv | 141 ++++++++++++++
 tb/tb_data_mem_responder.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the data-memory responder.
//   - RV32I load/store funct3 codes
//   - responder FSM state encoding (IDLE/BUSY/RESP, 2 bits)
//   - is_legal_funct3(we, f3): 1 when funct3 names a real load (we=0)
//     or store (we=1) of the RV32I base set
package riscv_mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic is_legal_funct3(input logic we, input logic [2:0] f3);
    if (we) begin
      return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    end
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering between a 32-bit RAM word and the
// RV32I load/store data formats.
// Ports:
//   i_word       current RAM word at the target index
//   i_lane       byte offset within the word (addr[1:0])
//   i_funct3     RV32I funct3 of the access
//   i_wdata      store data (low byte/half/word used)
//   o_load_data  aligned and sign/zero-extended load result
//   o_store_word i_word with the store bytes merged in
//   o_misalign   half access on an odd address or word access off a word boundary
module mem_lane_align
  import riscv_mem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_lane,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load_data,
  output logic [31:0] o_store_word,
  output logic        o_misalign
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [3:0]  w_be;
  logic [31:0] w_sdata;

  always_comb begin
    case (i_lane)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
    w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];

    o_load_data = 32'h0;
    o_misalign  = 1'b0;
    w_be        = 4'b0000;
    w_sdata     = i_wdata;

    // Store codes share values with LB/LH/LW; LBU/LHU codes carry no byte
    // enables, so an illegal store can never modify the word here.
    case (i_funct3)
      F3_LB: begin
        o_load_data = {{24{w_byte[7]}}, w_byte};
        w_be        = 4'b0001 << i_lane;
        w_sdata     = {4{i_wdata[7:0]}};
      end
      F3_LH: begin
        o_load_data = {{16{w_half[15]}}, w_half};
        o_misalign  = i_lane[0];
        w_be        = i_lane[1] ? 4'b1100 : 4'b0011;
        w_sdata     = {2{i_wdata[15:0]}};
      end
      F3_LW: begin
        o_load_data = i_word;
        o_misalign  = |i_lane;
        w_be        = 4'b1111;
      end
      F3_LBU: begin
        o_load_data = {24'h0, w_byte};
      end
      F3_LHU: begin
        o_load_data = {16'h0, w_half};
        o_misalign  = i_lane[0];
      end
      default: begin
        o_load_data = 32'h0;
      end
    endcase
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign o_store_word[8*gi +: 8] = w_be[gi] ? w_sdata[8*gi +: 8] : i_word[8*gi +: 8];
    end
  endgenerate

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory slave for the RV32I load/store path. Accepts one request in
// IDLE, waits LATENCY cycles in BUSY, performs the access on a word RAM and
// returns a one-cycle response.
// Ports:
//   clk1, rst          clock and synchronous active-high reset
//   req_valid/ready    request handshake (ready is high only in IDLE)
//   req_we, req_funct3 store/load select and RV32I access width
//   req_addr, req_wdata byte address and store data
//   rsp_valid          one-cycle response pulse
//   rsp_rdata, rsp_err load data (0 for stores/errors) and reject flag
module data_mem_responder
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk1,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);
  localparam logic [29:0] DEPTH_W  = 30'(DEPTH);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_ready;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;

  logic        r_we;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rd_word;

  logic [31:0] r_mem [DEPTH];

  logic [AW-1:0] w_in_idx;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_load_data;
  logic [31:0]   w_store_word;
  logic          w_misalign;
  logic          w_oor;
  logic          w_err;
  logic          w_access;
  logic          w_do_write;

  assign w_in_idx = req_addr[AW+1:2];
  assign w_idx    = r_addr[AW+1:2];

  mem_lane_align u_align (
    .i_word       (r_rd_word),
    .i_lane       (r_addr[1:0]),
    .i_funct3     (r_funct3),
    .i_wdata      (r_wdata),
    .o_load_data  (w_load_data),
    .o_store_word (w_store_word),
    .o_misalign   (w_misalign)
  );

  // Full word index is compared, so addresses aliasing onto the RAM through
  // the truncated index are rejected rather than wrapped.
  assign w_oor      = (r_addr[31:2] >= DEPTH_W);
  assign w_err      = w_oor | w_misalign | ~is_legal_funct3(r_we, r_funct3);
  assign w_access   = (r_state == BUSY) && (r_cnt == 4'd0);
  assign w_do_write = ~rst & w_access & r_we & ~w_err;

  always_ff @(posedge clk1) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_ready     <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'h0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_cnt    <= CNT_INIT;
            r_ready  <= 1'b0;
            r_state  <= BUSY;
          end
        end
        BUSY: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= w_err;
            r_rsp_rdata <= (w_err || r_we) ? 32'h0 : w_load_data;
            r_state     <= RESP;
          end
        end
        RESP: begin
          r_rsp_valid <= 1'b0;
          r_rsp_rdata <= 32'h0;
          r_rsp_err   <= 1'b0;
          r_ready     <= 1'b1;
          r_state     <= IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // RAM port: the word is read on the accept edge (registered read), held
  // through BUSY, and the merged word is written back on the access edge.
  always_ff @(posedge clk1) begin
    if (r_state == IDLE) begin
      r_rd_word <= r_mem[w_in_idx];
    end
    if (w_do_write) begin
      r_mem[w_idx] <= w_store_word;
    end
  end

  assign req_ready = r_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  localparam int DEPTH   = 1024;
  localparam int LATENCY = 2;

  logic        clk1 = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int total = 0;
  int bad   = 0;

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk1       (clk1),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  always #5 clk1 = ~clk1;

  // Reference memory: plain byte array covering the low 256 bytes.
  logic [7:0] mb [256];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model from the access rules: size, alignment, legality, range.
  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int size;
    logic legal;
    longint v;
    size = 1;
    if (f3 == 3'd1 || f3 == 3'd5) size = 2;
    if (f3 == 3'd2) size = 4;
    legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    er = !legal || ((a / 4) >= DEPTH) || ((a % size) != 0);
    rd = 32'h0;
    if (!er) begin
      if (we) begin
        for (int i = 0; i < size; i++)
          if (a + i < 256) mb[a + i] = wd[8*i +: 8];
      end else begin
        v = 0;
        for (int i = 0; i < size; i++)
          if (a + i < 256) v = v + (longint'(mb[a + i]) << (8 * i));
        if (f3 < 3'd4 && size < 4 && v >= (longint'(1) << (8 * size - 1)))
          v = v - (longint'(1) << (8 * size));
        rd = 32'(v);
      end
    end
  endfunction

  // One complete transaction starting at a negedge; checks latency and pulse width.
  task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, output logic [31:0] rd, output logic er,
                     output bit got);
    int n;
    got = 0;
    rd = 32'h0;
    er = 1'b0;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk1);
      n++;
    end
    if (!req_ready) begin
      chk("ready_timeout", {31'h0, req_ready}, 32'h1);
      return;
    end
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk1);
    #1 req_valid = 1'b0;
    n = 0;
    while (n < LATENCY + 20) begin
      @(negedge clk1);
      n++;
      if (rsp_valid) begin
        got = 1;
        break;
      end
    end
    chk("rsp_seen", {31'h0, got}, 32'h1);
    if (!got) return;
    chk("latency", n, LATENCY + 1);
    rd = rsp_rdata;
    er = rsp_err;
    @(negedge clk1);
    chk("pulse_width", {31'h0, rsp_valid}, 32'h0);
  endtask

  task automatic run_model(input string name, input logic we, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] erd, rd;
    logic eer, er;
    bit got;
    model(we, f3, a, wd, erd, eer);
    txn(we, f3, a, wd, rd, er, got);
    if (got) begin
      chk({name, "_rdata"}, rd, erd);
      chk({name, "_err"}, {31'h0, er}, {31'h0, eer});
    end
    $display("txn %s we=%0d f3=%0d addr=%h wdata=%h -> rdata=%h err=%0d", name, we, f3, a, wd, rd, er);
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t tbl[18];

  task automatic rst_mid(input int delay);
    int pulses;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h20; req_wdata = 32'h12345678;
    @(posedge clk1);
    #1 req_valid = 1'b0;
    @(negedge clk1);
    for (int d = 1; d < delay; d++) @(negedge clk1);
    rst = 1'b1;
    @(posedge clk1);
    @(negedge clk1);
    chk("rstmid_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rstmid_ready", {31'h0, req_ready}, 32'h1);
    chk("rstmid_rdata", rsp_rdata, 32'h0);
    chk("rstmid_err", {31'h0, rsp_err}, 32'h0);
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk1);
      if (rsp_valid) pulses++;
    end
    chk("rstmid_no_rsp", pulses, 0);
    $display("txn rst_mid delay=%0d pulses=%0d", delay, pulses);
    run_model("rstmid_lw20", 1'b0, 3'd2, 32'h20, 32'h0);
  endtask

  initial begin
    logic [31:0] rd;
    logic er;
    bit got;
    logic [31:0] q_rd [$];
    logic        q_er [$];
    logic [31:0] e_rd [3];
    logic        e_er [3];

    foreach (mb[i]) mb[i] = 8'h00;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(posedge clk1);
    @(negedge clk1);
    chk("reset_ready", {31'h0, req_ready}, 32'h1);
    chk("reset_valid", {31'h0, rsp_valid}, 32'h0);
    chk("reset_rdata", rsp_rdata, 32'h0);
    chk("reset_err", {31'h0, rsp_err}, 32'h0);
    rst = 1'b0;
    @(negedge clk1);

    // Directed table (expected values worked out by hand).
    tbl[0]  = '{1'b1, 3'd2, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0};
    tbl[1]  = '{1'b0, 3'd2, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b1, 3'd0, 32'h11,   32'h00000055, 32'h0,        1'b0};
    tbl[3]  = '{1'b0, 3'd2, 32'h10,   32'h0,        32'hDEAD55EF, 1'b0};
    tbl[4]  = '{1'b0, 3'd0, 32'h13,   32'h0,        32'hFFFFFFDE, 1'b0};
    tbl[5]  = '{1'b0, 3'd4, 32'h13,   32'h0,        32'h000000DE, 1'b0};
    tbl[6]  = '{1'b0, 3'd0, 32'h10,   32'h0,        32'hFFFFFFEF, 1'b0};
    tbl[7]  = '{1'b0, 3'd1, 32'h10,   32'h0,        32'h000055EF, 1'b0};
    tbl[8]  = '{1'b1, 3'd1, 32'h12,   32'h00008001, 32'h0,        1'b0};
    tbl[9]  = '{1'b0, 3'd1, 32'h12,   32'h0,        32'hFFFF8001, 1'b0};
    tbl[10] = '{1'b0, 3'd5, 32'h12,   32'h0,        32'h00008001, 1'b0};
    tbl[11] = '{1'b0, 3'd2, 32'h10,   32'h0,        32'h800155EF, 1'b0};
    tbl[12] = '{1'b0, 3'd2, 32'h11,   32'h0,        32'h0,        1'b1};
    tbl[13] = '{1'b1, 3'd1, 32'h13,   32'hFFFFFFFF, 32'h0,        1'b1};
    tbl[14] = '{1'b0, 3'd2, 32'h1000, 32'h0,        32'h0,        1'b1};
    tbl[15] = '{1'b0, 3'd3, 32'h10,   32'h0,        32'h0,        1'b1};
    tbl[16] = '{1'b1, 3'd4, 32'h1010, 32'h11111111, 32'h0,        1'b1};
    tbl[17] = '{1'b0, 3'd2, 32'h10,   32'h0,        32'h800155EF, 1'b0};

    for (int i = 0; i < 18; i++) begin
      logic [31:0] mrd;
      logic mer;
      model(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, mrd, mer);
      txn(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, rd, er, got);
      if (got) begin
        chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rdata);
        chk($sformatf("tbl%0d_err", i), {31'h0, er}, {31'h0, tbl[i].exp_err});
      end
      $display("txn tbl%0d we=%0d f3=%0d addr=%h wdata=%h -> rdata=%h err=%0d",
               i, tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, rd, er);
    end

    // req_valid held high across three requests.
    model(1'b1, 3'd2, 32'h30, 32'hCAFEF00D, e_rd[0], e_er[0]);
    model(1'b0, 3'd2, 32'h30, 32'h0, e_rd[1], e_er[1]);
    model(1'b0, 3'd4, 32'h31, 32'h0, e_rd[2], e_er[2]);
    fork
      begin
        logic        bw [3];
        logic [2:0]  bf [3];
        logic [31:0] ba [3];
        logic [31:0] bd [3];
        int n;
        bw = '{1'b1, 1'b0, 1'b0};
        bf = '{3'd2, 3'd2, 3'd4};
        ba = '{32'h30, 32'h30, 32'h31};
        bd = '{32'hCAFEF00D, 32'h0, 32'h0};
        req_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
          req_we = bw[k]; req_funct3 = bf[k]; req_addr = ba[k]; req_wdata = bd[k];
          n = 0;
          while (!req_ready && n < 50) begin
            @(negedge clk1);
            n++;
          end
          chk("b2b_accept", {31'h0, req_ready}, 32'h1);
          @(posedge clk1);
          #1;
        end
        req_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 60; c++) begin
          @(negedge clk1);
          if (rsp_valid) begin
            q_rd.push_back(rsp_rdata);
            q_er.push_back(rsp_err);
            chk("b2b_ready_low", {31'h0, req_ready}, 32'h0);
          end
        end
      end
    join
    chk("b2b_count", q_rd.size(), 3);
    for (int k = 0; k < 3 && k < q_rd.size(); k++) begin
      chk($sformatf("b2b%0d_rdata", k), q_rd[k], e_rd[k]);
      chk($sformatf("b2b%0d_err", k), {31'h0, q_er[k]}, {31'h0, e_er[k]});
      $display("txn b2b%0d -> rdata=%h err=%0d", k, q_rd[k], q_er[k]);
    end

    // Reset during a pending store: one cycle after accept, and on the access edge.
    run_model("pre_sw20", 1'b1, 3'd2, 32'h20, 32'h0);
    rst_mid(1);
    rst_mid(2);

    // Randomised phase against the model.
    for (int w = 0; w < 16; w++)
      run_model($sformatf("preload%0d", w), 1'b1, 3'd2, 32'(w * 4), $urandom);
    for (int t = 0; t < 200; t++) begin
      logic [31:0] a;
      if ($urandom_range(0, 9) == 0) a = $urandom | 32'h0000_1000;
      else a = 32'($urandom_range(0, 63));
      run_model($sformatf("rnd%0d", t), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                a, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
